// File: rtl/pkt_data_cache_if.sv
// Parser-facing write port, release-request port, output stream and statistics of pkt_data_cache.
// The cache owns the slave view; the upstream/downstream driver owns the master view.
interface pkt_data_cache_if;
  logic         in_data_wr;
  logic [133:0] in_data;
  logic         in_valid_wr;
  logic         in_valid;
  logic         out_data_alf;
  logic         in_rd_req;
  logic         in_rd_discard;
  logic         out_rd_ready;
  logic         out_data_wr;
  logic [133:0] out_data;
  logic         in_next_alf;
  logic [31:0]  out_in_pkt_cnt;
  logic [31:0]  out_drop_cnt;
  logic [31:0]  out_out_pkt_cnt;

  modport slave (
    input  in_data_wr, in_data, in_valid_wr, in_valid, in_rd_req, in_rd_discard, in_next_alf,
    output out_data_alf, out_rd_ready, out_data_wr, out_data,
           out_in_pkt_cnt, out_drop_cnt, out_out_pkt_cnt
  );

  modport master (
    output in_data_wr, in_data, in_valid_wr, in_valid, in_rd_req, in_rd_discard, in_next_alf,
    input  out_data_alf, out_rd_ready, out_data_wr, out_data,
           out_in_pkt_cnt, out_drop_cnt, out_out_pkt_cnt
  );
endinterface

// File: rtl/pkt_data_cache.sv
// Packet buffer behind the parser: speculative write with commit/rollback on the tail flag,
// in-order release of committed packets (stream or discard), almost-full flag and statistics.
module pkt_data_cache #(
  parameter int DATA_AW    = 8,
  parameter int DESC_AW    = 6,
  parameter int ALF_MARGIN = 32
) (
  input logic            clk,
  input logic            rst,
  pkt_data_cache_if.slave bus
);

  localparam int PW         = DATA_AW + 1;
  localparam int DEPTH      = 1 << DATA_AW;
  localparam int DESC_DEPTH = 1 << DESC_AW;
  localparam logic [DATA_AW:0] DEPTH_W    = {1'b1, {DATA_AW{1'b0}}};
  localparam logic [DATA_AW:0] ALF_W      = PW'(ALF_MARGIN);
  localparam logic [DESC_AW:0] DESC_FULL  = {1'b1, {DESC_AW{1'b0}}};
  localparam logic [DESC_AW:0] DESC_ALF   = DESC_FULL - (DESC_AW + 1)'(2);

  typedef enum logic [0:0] {IDLE, SEND} rdState_e;

  logic [133:0]      r_mem [DEPTH];
  logic [2*PW-1:0]   r_desc [DESC_DEPTH];
  logic [DATA_AW:0]  r_wrPtr, r_commitPtr, r_rdPtr, r_pktLen, r_remain;
  logic              r_inPkt, r_ovf;
  logic [DESC_AW-1:0] r_descWr, r_descRd;
  logic [DESC_AW:0]  r_descCount;
  rdState_e          r_state;
  logic              r_rdReady, r_outWr, r_alf;
  logic [133:0]      r_outData;
  logic [31:0]       r_inCnt, r_dropCnt, r_outCnt;

  logic              w_isHead, w_accept, w_full, w_wrEn, w_rollback, w_pktActive, w_ovfNext;
  logic              w_close, w_commit, w_abort, w_pop, w_discard, w_issue;
  logic [DATA_AW:0]  w_wrAddr, w_wrPtrNext, w_lenNext, w_used, w_free;
  logic [DATA_AW:0]  w_headStart, w_headLen;
  logic [DESC_AW:0]  w_descCountNext;
  logic [133:0]      w_rdWord;
  logic [31:0]       w_dropInc;

  // A head always lands at commit_ptr, which also rolls back any unfinished packet.
  always_comb begin
    w_isHead    = (bus.in_data[133:132] == 2'b01);
    w_accept    = bus.in_data_wr && (w_isHead || r_inPkt);
    w_wrAddr    = w_isHead ? r_commitPtr : r_wrPtr;
    w_full      = ((w_wrAddr - r_rdPtr) == DEPTH_W);
    w_wrEn      = w_accept && !w_full;
    w_rollback  = w_accept && w_isHead && r_inPkt;
    w_pktActive = r_inPkt || (w_accept && w_isHead);
    w_ovfNext   = (w_accept && w_isHead) ? w_full : (r_ovf || (w_accept && w_full));
    w_wrPtrNext = w_wrEn ? (w_wrAddr + 1'b1) : (w_accept ? w_wrAddr : r_wrPtr);
    if (w_wrEn)
      w_lenNext = w_isHead ? PW'(1) : (r_pktLen + 1'b1);
    else
      w_lenNext = (w_accept && w_isHead) ? '0 : r_pktLen;
    w_close     = bus.in_valid_wr && w_pktActive;
    w_commit    = w_close && bus.in_valid && !w_ovfNext && (r_descCount != DESC_FULL);
    w_abort     = w_close && !w_commit;
    w_pop       = bus.in_rd_req && r_rdReady;
    w_discard   = w_pop && bus.in_rd_discard;
    w_issue     = (r_state == SEND) && !bus.in_next_alf;
    w_descCountNext = r_descCount + (DESC_AW + 1)'(w_commit) - (DESC_AW + 1)'(w_pop);
    w_used      = r_wrPtr - r_rdPtr;
    w_free      = DEPTH_W - w_used;
    {w_headStart, w_headLen} = r_desc[r_descRd];
    w_rdWord    = r_mem[r_rdPtr[DATA_AW-1:0]];
    w_dropInc   = 32'(w_rollback) + 32'(w_abort) + 32'(w_discard);
  end

  always_ff @(posedge clk) begin
    if (w_wrEn)
      r_mem[w_wrAddr[DATA_AW-1:0]] <= bus.in_data;
    if (w_commit)
      r_desc[r_descWr] <= {r_commitPtr, w_lenNext};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_commitPtr <= '0;
      r_pktLen    <= '0;
      r_inPkt     <= 1'b0;
      r_ovf       <= 1'b0;
      r_descWr    <= '0;
      r_inCnt     <= '0;
    end else begin
      r_wrPtr  <= w_wrPtrNext;
      r_pktLen <= w_lenNext;
      r_ovf    <= w_ovfNext;
      if (w_accept)
        r_inPkt <= 1'b1;
      if (w_commit) begin
        r_descWr    <= r_descWr + 1'b1;
        r_commitPtr <= w_wrPtrNext;
        r_inCnt     <= r_inCnt + 32'd1;
        r_inPkt     <= 1'b0;
      end else if (w_abort) begin
        r_wrPtr <= r_commitPtr;
        r_inPkt <= 1'b0;
      end
    end
  end

  // Shared bookkeeping; drops from the write and read sides can coincide and both count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_descCount <= '0;
      r_dropCnt   <= '0;
      r_alf       <= 1'b0;
    end else begin
      r_descCount <= w_descCountNext;
      r_dropCnt   <= r_dropCnt + w_dropInc;
      r_alf       <= (w_free < ALF_W) || (r_descCount >= DESC_ALF);
    end
  end

  // The RAM read register doubles as the output register, so issue at C shows at C+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rdReady <= 1'b0;
      r_rdPtr   <= '0;
      r_remain  <= '0;
      r_descRd  <= '0;
      r_outWr   <= 1'b0;
      r_outData <= '0;
      r_outCnt  <= '0;
    end else begin
      r_outWr <= w_issue;
      if (w_issue) begin
        r_outData <= w_rdWord;
        if (w_rdWord[133:132] == 2'b10)
          r_outCnt <= r_outCnt + 32'd1;
      end
      case (r_state)
        IDLE: begin
          r_rdReady <= (w_descCountNext != '0);
          if (w_pop) begin
            r_descRd <= r_descRd + 1'b1;
            if (bus.in_rd_discard) begin
              r_rdPtr <= w_headStart + w_headLen;
            end else begin
              r_rdPtr   <= w_headStart;
              r_remain  <= w_headLen;
              r_state   <= SEND;
              r_rdReady <= 1'b0;
            end
          end
        end
        SEND: begin
          r_rdReady <= 1'b0;
          if (w_issue) begin
            r_rdPtr  <= r_rdPtr + 1'b1;
            r_remain <= r_remain - 1'b1;
            if (r_remain == PW'(1)) begin
              r_state   <= IDLE;
              r_rdReady <= (w_descCountNext != '0);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_data_alf    = r_alf;
  assign bus.out_rd_ready    = r_rdReady;
  assign bus.out_data_wr     = r_outWr;
  assign bus.out_data        = r_outData;
  assign bus.out_in_pkt_cnt  = r_inCnt;
  assign bus.out_drop_cnt    = r_dropCnt;
  assign bus.out_out_pkt_cnt = r_outCnt;

endmodule

// File: doc/pkt_data_cache.md
# pkt_data_cache

Packet buffer directly downstream of the GPP parser stage. It stores every packet word the parser retransmits and commits or rolls back each packet on the tail-cycle valid flag. It then releases committed packets in arrival order, one per release request, either streamed to the next stage or silently discarded. It exports an almost-full flag back to the parser and 32-bit packet statistics.

## Interface
- DATA_AW, 8: log2 of data RAM depth in 134-bit words (DEPTH = 2^DATA_AW = 256).
- DESC_AW, 6: log2 of descriptor FIFO depth in packets (64).
- ALF_MARGIN, 32: free-word threshold for out_data_alf.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data_wr  input  1  packet word strobe from parser.
- in_data  input  134  packet word; [133:132] 01 head, 11 body, 10 tail; [127:0] payload.
- in_valid_wr  input  1  asserted on the tail-word cycle.
- in_valid  input  1  1 = commit packet, 0 = drop; sampled with in_valid_wr.
- out_data_alf  output  1  almost-full to parser.
- in_rd_req  input  1  release request for oldest committed packet.
- in_rd_discard  input  1  with in_rd_req: 1 = drop packet, 0 = transmit.
- out_rd_ready  output  1  request will be accepted this cycle.
- out_data_wr  output  1  output word strobe.
- out_data  output  134  output word, unmodified copy of stored word.
- in_next_alf  input  1  downstream almost-full; stalls reads.
- out_in_pkt_cnt  output  32  committed packets.
- out_drop_cnt  output  32  packets dropped (invalid, overflow, truncated, or discarded).
- out_out_pkt_cnt  output  32  packets fully transmitted.

## Operation
- Write side:
  - Pointers: wr_ptr (speculative), commit_ptr, rd_ptr, each DATA_AW+1 bits; RAM addressed by the low DATA_AW bits.
  - in_pkt flag and pkt_len counter (DATA_AW+1 bits).
  - Head word: write RAM[wr_ptr], wr_ptr+1, pkt_len=1, in_pkt=1, ovf=0.
  - Body or tail word with in_pkt=1: written the same way, pkt_len+1.
  - Word with in_pkt=0 that is not a head: ignored.
  - Head while in_pkt=1: partial packet rolled back (wr_ptr<=commit_ptr before the new head is written at commit_ptr); out_drop_cnt+1.
  - Data RAM full: used = wr_ptr-rd_ptr == DEPTH. Arriving word is not written and ovf is set.
  - Commit, at in_valid_wr: in_valid=1, ovf=0 and descriptor FIFO not full. Push {start=commit_ptr, len=pkt_len incl. tail}; commit_ptr <= wr_ptr incl. tail; out_in_pkt_cnt+1.
  - Otherwise at in_valid_wr: wr_ptr <= commit_ptr, out_drop_cnt+1. in_pkt cleared either way.
- out_data_alf = (DEPTH - used) < ALF_MARGIN OR desc_count >= 2^DESC_AW - 2. Registered.
- Read FSM, states IDLE, SEND:
  - out_rd_ready = (state==IDLE) && desc_count != 0. A request while not ready is ignored; no queueing.
  - IDLE, accepted request with in_rd_discard=1: pop descriptor, rd_ptr += len, out_drop_cnt+1, stay IDLE.
  - IDLE, accepted request with in_rd_discard=0: pop descriptor, remain=len, go to SEND.
  - SEND: each cycle with in_next_alf=0, issue RAM read at rd_ptr, rd_ptr+1, remain-1. On the last issue, go to IDLE.
  - The RAM has one-cycle synchronous read; out_data_wr/out_data are registered from the read data.
  - out_out_pkt_cnt+1 when the word with [133:132]=10 is emitted.
- Simultaneous write commit and read pop: both take effect; desc_count unchanged.
- Simultaneous drop (two sources in one cycle, e.g. discard and write rollback): out_drop_cnt += 2.
- Counters wrap modulo 2^32.

## Timing
- Reset: every output 0; all pointers 0; FSM in IDLE; descriptor FIFO empty; in_pkt 0. Reset mid-packet discards all buffered data.
- Commit latency: a tail in cycle T gives out_rd_ready=1 at T+1.
- Request accepted at T: first read issued at T+1, head on out_data at T+2. Without stall, N words take T+2..T+N+1 contiguously.
- Stall: in_next_alf high in cycle C means no read is issued in C. The word issued at C-1 still appears at C. This gives at most 1 word of overshoot after alf rises.
- out_data_alf is updated 1 cycle after the pointer change.
- Space freed by rd_ptr is visible to the write side the next cycle.

## Test plan
- Reset with stimulus active -> all outputs 0, out_rd_ready=0, out_data_alf=0; after release the first packet stores normally.
- 4-word packet (01,11,11,10), in_valid=1; rd_req at T -> identical 4 words at T+2..T+5; out_in_pkt_cnt=1, out_out_pkt_cnt=1.
- 3-word packet with in_valid=0 -> out_rd_ready stays 0, out_drop_cnt=1. Then a 256-word packet commits without overflow, confirming rollback.
- in_next_alf high 3 cycles mid-way through an 8-word transmit -> output pauses, at most 1 overshoot word, 8 words total, in order, no duplicates.
- Write 64-word packets until data overflows -> out_data_alf asserts once free space is below 32. The overflowing 5th packet is dropped; packets 1-4 read back intact.
- Three packets committed; rd_req+discard on packet 1 in the same cycle packet 3's tail commits -> out_drop_cnt=1, desc_count stays 2. Next two reads return packets 2 and 3.
